// File: rtl/cnn_layer_sequencer.sv
// Layer scheduler for the CNN pipeline: launches engines in order through init/done,
// multiplexes the shared param/fmap bank ports onto the active layer, and runs a per-layer watchdog.
module cnn_layer_sequencer #(
    parameter int N_LAYERS     = 6,
    parameter int IDX_W        = 3,
    parameter int TIMEOUT      = 2000000,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [IDX_W-1:0]       cur_layer,
    output logic [3:0]             label,
    input  logic [3:0]             label_in,
    output logic [N_LAYERS-1:0]    layer_init,
    input  logic [N_LAYERS-1:0]    layer_done,
    input  logic [N_LAYERS*16-1:0] l_pbank_addr,
    input  logic [N_LAYERS-1:0]    l_pbank_en,
    input  logic [N_LAYERS*15-1:0] l_fbank_raddr,
    input  logic [N_LAYERS-1:0]    l_fbank_ren,
    input  logic [N_LAYERS*15-1:0] l_fbank_waddr,
    input  logic [N_LAYERS*8-1:0]  l_fdata_w,
    input  logic [N_LAYERS-1:0]    l_fbank_wen,
    output logic [15:0]            pbank_addr,
    output logic                   pbank_en,
    output logic [14:0]            fbank_raddr,
    output logic                   fbank_ren,
    output logic [14:0]            fbank_waddr,
    output logic [7:0]             fdata_w,
    output logic                   fbank_wen
);

    localparam int WD_NEED = $clog2(TIMEOUT + 1);
    localparam int WD_W    = (WD_NEED > 22) ? WD_NEED : 22;
    localparam int DR_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DRAIN,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic [DR_W-1:0]     drain_q, drain_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [3:0]          label_q, label_d;
    logic [N_LAYERS-1:0] init_q, init_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wdog_q  <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            label_q <= '0;
            init_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wdog_q  <= wdog_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            label_q <= label_d;
            init_q  <= init_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wdog_d  = wdog_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wdog_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (wdog_q != WD_W'(TIMEOUT)) begin
                    wdog_d = wdog_q + 1'b1;
                end
                // done is checked first so it wins over a coincident timeout
                if (layer_done[idx_q]) begin
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = S_ERROR;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DR_W'(DRAIN_CYCLES - 1)) begin
                    if (idx_q == IDX_W'(N_LAYERS - 1)) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_ERROR: begin
                if (start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are derived from the next state so they line up with the state itself.
    always_comb begin
        busy_d  = (state_d == S_LAUNCH) || (state_d == S_RUN) ||
                  (state_d == S_DRAIN)  || (state_d == S_FINISH);
        done_d  = (state_d == S_FINISH);
        error_d = (state_d == S_ERROR);
        init_d  = '0;
        if (state_d == S_LAUNCH) begin
            init_d = {{(N_LAYERS-1){1'b0}}, 1'b1} << idx_d;
        end
        label_d = label_q;
        if (state_d == S_FINISH) begin
            label_d = label_in;
        end
    end

    logic [15:0] pa_arr [N_LAYERS];
    logic [14:0] ra_arr [N_LAYERS];
    logic [14:0] wa_arr [N_LAYERS];
    logic [7:0]  wd_arr [N_LAYERS];

    generate
        for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_unpack
            assign pa_arr[gi] = l_pbank_addr[gi*16 +: 16];
            assign ra_arr[gi] = l_fbank_raddr[gi*15 +: 15];
            assign wa_arr[gi] = l_fbank_waddr[gi*15 +: 15];
            assign wd_arr[gi] = l_fdata_w[gi*8 +: 8];
        end
    endgenerate

    logic grant;
    assign grant = (state_q == S_LAUNCH) || (state_q == S_RUN) || (state_q == S_DRAIN);

    always_comb begin
        pbank_addr  = '0;
        pbank_en    = 1'b0;
        fbank_raddr = '0;
        fbank_ren   = 1'b0;
        fbank_waddr = '0;
        fdata_w     = '0;
        fbank_wen   = 1'b0;
        if (grant) begin
            pbank_addr  = pa_arr[idx_q];
            pbank_en    = l_pbank_en[idx_q];
            fbank_raddr = ra_arr[idx_q];
            fbank_ren   = l_fbank_ren[idx_q];
            fbank_waddr = wa_arr[idx_q];
            fdata_w     = wd_arr[idx_q];
            fbank_wen   = l_fbank_wen[idx_q];
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cur_layer  = idx_q;
    assign label      = label_q;
    assign layer_init = init_q;

endmodule
